// File: rtl/dwconv_pre_ctrl.sv
// Frame sequencer for the depthwise-conv pre-process path: latches W/H/stride, programs the row buffer, tracks pixel (c,r)
// and flags legal windows one cycle after the completing pixel; pix_ready is high only in RUN, and ignored pixels never count.
module dwconv_pre_ctrl #(
  parameter int ROW_BUFFER_DEPTH = 9,
  parameter int COORD_WIDTH      = 9
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        cfg_start,
  input  logic [COORD_WIDTH-1:0]      cfg_width,
  input  logic [COORD_WIDTH-1:0]      cfg_height,
  input  logic                        cfg_stride,
  input  logic                        pix_valid,
  output logic                        pix_ready,
  output logic [ROW_BUFFER_DEPTH-1:0] buff_len_ctrl,
  output logic                        buff_len_rst,
  output logic                        win_valid,
  output logic [COORD_WIDTH-1:0]      win_col,
  output logic [COORD_WIDTH-1:0]      win_row,
  output logic                        frame_done,
  output logic                        busy,
  output logic                        cfg_err
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

  state_t                      r_state;
  logic [COORD_WIDTH-1:0]      r_width;
  logic [COORD_WIDTH-1:0]      r_height;
  logic                        r_stride;
  logic [COORD_WIDTH-1:0]      r_col;
  logic [COORD_WIDTH-1:0]      r_row;
  logic                        r_pix_ready;
  logic [ROW_BUFFER_DEPTH-1:0] r_buff_len;
  logic                        r_buff_len_rst;
  logic                        r_win_valid;
  logic [COORD_WIDTH-1:0]      r_win_col;
  logic [COORD_WIDTH-1:0]      r_win_row;
  logic                        r_frame_done;
  logic                        r_busy;
  logic                        r_cfg_err;

  logic                        w_cfg_legal;
  logic                        w_win_legal;
  logic                        w_col_last;
  logic                        w_row_last;
  logic [COORD_WIDTH-1:0]      w_col_m2;
  logic [COORD_WIDTH-1:0]      w_row_m2;

  // Width check done in 64 bits so W-2 can be compared against the full row-buffer range.
  assign w_cfg_legal = (cfg_width >= COORD_WIDTH'(3)) && (cfg_height >= COORD_WIDTH'(3)) &&
                       ((64'(cfg_width) - 64'd2) <= ((64'd1 << ROW_BUFFER_DEPTH) - 64'd1));

  assign w_win_legal = (r_col >= COORD_WIDTH'(2)) && (r_row >= COORD_WIDTH'(2)) &&
                       (!r_stride || (!r_col[0] && !r_row[0]));
  assign w_col_last  = (r_col == r_width - COORD_WIDTH'(1));
  assign w_row_last  = (r_row == r_height - COORD_WIDTH'(1));
  assign w_col_m2    = r_col - COORD_WIDTH'(2);
  assign w_row_m2    = r_row - COORD_WIDTH'(2);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state        <= S_IDLE;
      r_width        <= '0;
      r_height       <= '0;
      r_stride       <= 1'b0;
      r_col          <= '0;
      r_row          <= '0;
      r_pix_ready    <= 1'b0;
      r_buff_len     <= '0;
      r_buff_len_rst <= 1'b0;
      r_win_valid    <= 1'b0;
      r_win_col      <= '0;
      r_win_row      <= '0;
      r_frame_done   <= 1'b0;
      r_busy         <= 1'b0;
      r_cfg_err      <= 1'b0;
    end else begin
      r_buff_len_rst <= 1'b0;
      r_frame_done   <= 1'b0;
      r_win_valid    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (cfg_start) begin
            if (w_cfg_legal) begin
              r_width        <= cfg_width;
              r_height       <= cfg_height;
              r_stride       <= cfg_stride;
              r_buff_len     <= ROW_BUFFER_DEPTH'(cfg_width - COORD_WIDTH'(2));
              r_cfg_err      <= 1'b0;
              r_buff_len_rst <= 1'b1;
              r_busy         <= 1'b1;
              r_state        <= S_LOAD;
            end else begin
              r_cfg_err <= 1'b1;
            end
          end
        end
        S_LOAD: begin
          r_col       <= '0;
          r_row       <= '0;
          r_pix_ready <= 1'b1;
          r_state     <= S_RUN;
        end
        S_RUN: begin
          if (pix_valid) begin
            if (w_win_legal) begin
              r_win_valid <= 1'b1;
              r_win_col   <= w_col_m2 >> r_stride;
              r_win_row   <= w_row_m2 >> r_stride;
            end
            if (w_col_last) begin
              r_col <= '0;
              if (w_row_last) begin
                r_pix_ready  <= 1'b0;
                r_frame_done <= 1'b1;
                r_state      <= S_DONE;
              end else begin
                r_row <= r_row + COORD_WIDTH'(1);
              end
            end else begin
              r_col <= r_col + COORD_WIDTH'(1);
            end
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign pix_ready     = r_pix_ready;
  assign buff_len_ctrl = r_buff_len;
  assign buff_len_rst  = r_buff_len_rst;
  assign win_valid     = r_win_valid;
  assign win_col       = r_win_col;
  assign win_row       = r_win_row;
  assign frame_done    = r_frame_done;
  assign busy          = r_busy;
  assign cfg_err       = r_cfg_err;

endmodule

// File: tb/tb_dwconv_pre_ctrl.sv
// Directed bench for dwconv_pre_ctrl: table of frames with expected window counts/positions plus
// hand sequences for illegal configs and a mid-frame asynchronous reset.
module tb_dwconv_pre_ctrl;
  localparam int RBD = 9;
  localparam int CW  = 10;

  logic           clk = 1'b0;
  logic           rstn = 1'b0;
  logic           cfg_start = 1'b0;
  logic [CW-1:0]  cfg_width = '0;
  logic [CW-1:0]  cfg_height = '0;
  logic           cfg_stride = 1'b0;
  logic           pix_valid = 1'b0;
  logic           pix_ready;
  logic [RBD-1:0] buff_len_ctrl;
  logic           buff_len_rst;
  logic           win_valid;
  logic [CW-1:0]  win_col;
  logic [CW-1:0]  win_row;
  logic           frame_done;
  logic           busy;
  logic           cfg_err;

  dwconv_pre_ctrl #(.ROW_BUFFER_DEPTH(RBD), .COORD_WIDTH(CW)) dut (
    .clk(clk), .rstn(rstn), .cfg_start(cfg_start), .cfg_width(cfg_width),
    .cfg_height(cfg_height), .cfg_stride(cfg_stride), .pix_valid(pix_valid),
    .pix_ready(pix_ready), .buff_len_ctrl(buff_len_ctrl), .buff_len_rst(buff_len_rst),
    .win_valid(win_valid), .win_col(win_col), .win_row(win_row),
    .frame_done(frame_done), .busy(busy), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int w; int h; int s; int gap; int inj;
    int nwin; int fc; int fr; int fpix; int lc; int lr; int lpix;
  } vec_t;

  int n_vec  = 0;
  int n_fail = 0;
  int wpix[$];
  int wc[$];
  int wr[$];

  task automatic chk(input string nm, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_rdy"},  pix_ready, 0);
    chk({nm, "_blen"}, buff_len_ctrl, 0);
    chk({nm, "_brst"}, buff_len_rst, 0);
    chk({nm, "_wv"},   win_valid, 0);
    chk({nm, "_wc"},   win_col, 0);
    chk({nm, "_wr"},   win_row, 0);
    chk({nm, "_done"}, frame_done, 0);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_err"},  cfg_err, 0);
  endtask

  // Drives one frame; checks every cycle against an independent coordinate model.
  task automatic run_frame(input int w, input int h, input int s, input int gap, input int inj);
    int k, cyc, c, r, el;
    bit drv;
    wpix.delete(); wc.delete(); wr.delete();
    @(negedge clk);
    cfg_start = 1'b1; cfg_width = CW'(w); cfg_height = CW'(h); cfg_stride = s[0];
    @(posedge clk); #1;
    cfg_start = 1'b0;
    chk("load_rst",  buff_len_rst, 1);
    chk("load_blen", buff_len_ctrl, w - 2);
    chk("load_busy", busy, 1);
    chk("load_rdy",  pix_ready, 0);
    chk("load_err",  cfg_err, 0);
    @(posedge clk); #1;
    chk("run_rdy", pix_ready, 1);
    chk("run_rst", buff_len_rst, 0);
    k = 0; cyc = 0;
    while (k < w * h) begin
      @(negedge clk);
      drv = (gap == 0) || (cyc % 2 == 0);
      pix_valid = drv;
      if (drv && k == inj) begin
        cfg_start = 1'b1; cfg_width = CW'(2);
      end
      @(posedge clk); #1;
      cfg_start = 1'b0; cfg_width = CW'(w);
      if (drv) begin
        c = k % w; r = k / w;
        el = (c >= 2 && r >= 2 && (s == 0 || (c % 2 == 0 && r % 2 == 0))) ? 1 : 0;
        k++;
        chk("win_valid", win_valid, el);
        if (el != 0) begin
          chk("win_col", win_col, (c - 2) >> s);
          chk("win_row", win_row, (r - 2) >> s);
          wpix.push_back(k); wc.push_back(int'(win_col)); wr.push_back(int'(win_row));
        end
      end else begin
        chk("gap_win", win_valid, 0);
      end
      chk("frame_done", frame_done, (k == w * h) ? 1 : 0);
      chk("rdy", pix_ready, (k < w * h) ? 1 : 0);
      if (inj >= 0 && k > inj) chk("inj_err", cfg_err, 0);
      cyc++;
    end
    pix_valid = 1'b0;
    @(posedge clk); #1;
    chk("idle_busy", busy, 0);
    chk("idle_done", frame_done, 0);
    chk("idle_blen", buff_len_ctrl, w - 2);
  endtask

  task automatic bad_start(input int w, input int h, input int prev_len);
    @(negedge clk);
    cfg_start = 1'b1; cfg_width = CW'(w); cfg_height = CW'(h); cfg_stride = 1'b0;
    @(posedge clk); #1;
    cfg_start = 1'b0;
    chk("bad_err",  cfg_err, 1);
    chk("bad_busy", busy, 0);
    chk("bad_brst", buff_len_rst, 0);
    chk("bad_blen", buff_len_ctrl, prev_len);
    @(posedge clk); #1;
    chk("bad_busy2", busy, 0);
    chk("bad_rdy2",  pix_ready, 0);
    chk("bad_err2",  cfg_err, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[6];
    int s2_pix[4] = '{15, 17, 27, 29};
    int s2_col[4] = '{0, 1, 0, 1};
    int s2_row[4] = '{0, 0, 1, 1};

    vt[0] = '{w:5,   h:4, s:0, gap:0, inj:-1, nwin:6,   fc:0, fr:0, fpix:13,   lc:2,   lr:1, lpix:20};
    vt[1] = '{w:6,   h:6, s:1, gap:0, inj:-1, nwin:4,   fc:0, fr:0, fpix:15,   lc:1,   lr:1, lpix:29};
    vt[2] = '{w:5,   h:4, s:0, gap:1, inj:-1, nwin:6,   fc:0, fr:0, fpix:13,   lc:2,   lr:1, lpix:20};
    vt[3] = '{w:513, h:3, s:0, gap:0, inj:-1, nwin:511, fc:0, fr:0, fpix:1029, lc:510, lr:0, lpix:1539};
    vt[4] = '{w:3,   h:3, s:0, gap:0, inj:-1, nwin:1,   fc:0, fr:0, fpix:9,    lc:0,   lr:0, lpix:9};
    vt[5] = '{w:5,   h:4, s:0, gap:0, inj:8,  nwin:6,   fc:0, fr:0, fpix:13,   lc:2,   lr:1, lpix:20};

    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("rst");
    @(negedge clk); rstn = 1'b1;
    @(posedge clk); #1;
    chk_all_zero("post_rst");

    for (int i = 0; i < 6; i++) begin
      run_frame(vt[i].w, vt[i].h, vt[i].s, vt[i].gap, vt[i].inj);
      chk("nwin", wpix.size(), vt[i].nwin);
      if (wpix.size() > 0) begin
        chk("first_col", wc[0], vt[i].fc);
        chk("first_row", wr[0], vt[i].fr);
        chk("first_pix", wpix[0], vt[i].fpix);
        chk("last_col",  wc[$], vt[i].lc);
        chk("last_row",  wr[$], vt[i].lr);
        chk("last_pix",  wpix[$], vt[i].lpix);
      end
      if (vt[i].s == 1 && wpix.size() == 4) begin
        for (int j = 0; j < 4; j++) begin
          chk("s2_pix", wpix[j], s2_pix[j]);
          chk("s2_col", wc[j], s2_col[j]);
          chk("s2_row", wr[j], s2_row[j]);
        end
      end
    end

    bad_start(2, 4, 3);
    bad_start(514, 4, 3);
    bad_start(5, 2, 3);
    run_frame(5, 4, 0, 0, -1);
    chk("clear_nwin", wpix.size(), 6);

    // Mid-frame abort after 7 accepted pixels.
    @(negedge clk);
    cfg_start = 1'b1; cfg_width = CW'(5); cfg_height = CW'(4); cfg_stride = 1'b0;
    @(posedge clk); #1;
    cfg_start = 1'b0;
    @(posedge clk); #1;
    for (int p = 0; p < 7; p++) begin
      @(negedge clk); pix_valid = 1'b1;
      @(posedge clk); #1;
    end
    chk("pre_abort_busy", busy, 1);
    @(negedge clk);
    pix_valid = 1'b0;
    #1 rstn = 1'b0;
    #1;
    chk_all_zero("abort");
    repeat (2) begin
      @(posedge clk); #1;
      chk("abort_done", frame_done, 0);
      chk("abort_busy", busy, 0);
    end
    @(negedge clk); rstn = 1'b1;
    run_frame(5, 4, 0, 0, -1);
    chk("after_nwin", wpix.size(), 6);
    if (wpix.size() > 0) begin
      chk("after_first_col", wc[0], 0);
      chk("after_first_row", wr[0], 0);
      chk("after_first_pix", wpix[0], 13);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
